uart_rx_fifo_driver: RTL and testbench
======================================

Name: uart_rx_fifo_driver

Overview:
- Parametrised UART receive driver for the MIPS CPU memory-mapped IO path.
- Deserialises PC→FPGA serial data and buffers bytes in an internal FIFO so the CPU cannot miss characters between reads.
- Exposes a 16-bit data/status read port selected by an address bit.
- Single clock domain: the CPU read strobe is sampled on the same clock as the receiver.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- UART_BPS, 128000: baud rate. CLKS_PER_BIT = CLK_FREQ/UART_BPS, integer-truncated.
- DATA_BITS, 8: data bits per frame, legal range 5..8, LSB first.
- FIFO_DEPTH, 16: receive FIFO entries. Must be a power of two, 2..128. AW = clog2(FIFO_DEPTH).

Ports:
- iFpgaClock  input  1  sole clock, rising-edge.
- iCpuReset  input  1  asynchronous, active-high reset.
- iUartFromPc  input  1  serial RX line; idles high; asynchronous to the clock.
- iUartCtrl  input  1  UART address decode from memorio.
- iIoRead  input  1  IO read enable from controller.
- iAddrSel  input  1  0 = data register, 1 = status register.
- oUartData  output  16  registered read data.
- oRxNotEmpty  output  1  FIFO holds ≥1 byte; usable as an interrupt/poll flag.

Behaviour:
- Reset (asynchronous):
  - oUartData = 16'h0000, oRxNotEmpty = 0.
  - FIFO pointers and count = 0; all sticky error flags = 0.
  - FSM = IDLE; synchroniser flops = 1; read-edge register = 0.
  - Reset asserted mid-frame aborts the frame with no push.
- Input synchronisation:
  - iUartFromPc passes through a 2-FF synchroniser before any use.
  - All sampling latencies below are measured from the synchronised signal.
- RX FSM:
  - IDLE: on a falling edge of the synchronised line → START; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 clocks, then sample.
    - Low → DATA.
    - High → glitch; return to IDLE with no flag set.
  - DATA: sample every CLKS_PER_BIT clocks. After DATA_BITS samples → PARITY if enabled, else STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - High → push the byte, zero-extended to 8 bits, if there is no pending error; → IDLE.
    - Low → set framing error, no push; → BREAK.
  - BREAK: wait until the line reads high, then → IDLE. A held-low line produces exactly one framing error.
- Read strobe:
  - rd = iUartCtrl & iIoRead.
  - Action happens on the rising edge of rd only, using a registered previous value, so a multi-cycle read pops exactly once.
  - oUartData updates on the clock edge where rd is first seen high; it holds between reads.
- Data read (iAddrSel = 0):
  - Non-empty: oUartData = {8'h00, head byte}, then pop.
  - Empty: oUartData = 16'h0000, pointers unchanged.
- Status read (iAddrSel = 1):
  - oUartData = {count[7:0], 3'b000, parity_err, framing_err, overrun, full, not_empty}.
  - Sticky bits (parity_err, framing_err, overrun) are cleared by the status read. Values captured are pre-clear.
  - An error event in the same cycle as a status read stays set.
- FIFO:
  - Count width AW+1.
  - Push while full with no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle: both occur, count unchanged. This applies when full as well.
  - Pointers wrap modulo FIFO_DEPTH.
  - oRxNotEmpty = (count != 0), registered, updated in the same cycle as count.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - FSM includes a PARITY state that samples one extra bit CLKS_PER_BIT after the last data bit. Even parity is expected.
  - Mismatch sets parity_err and suppresses the push, but the stop bit is still checked and may also set framing_err.
- Undefined:
  - No PARITY state; frames are start + DATA_BITS + stop.
  - Status bit 4 reads 0.

Test Plan:
- Reset, then read status → oUartData = 16'h0000, oRxNotEmpty = 0. Data read → 16'h0000.
- Send 0x41 at 128000 baud, then data read → oUartData = 16'h0041; following status read → 16'h0000.
- Send 0x01..0x10 (16 bytes) with no reads:
  - Status = 16'h1003.
  - 17th byte 0xAA → status bit2 set; sixteen data reads return 0x01..0x10, not 0xAA.
- Hold rd high for 10 cycles with two bytes queued → exactly one pop; status count = 1.
- Frame 0x55 with stop bit forced low → no push; status = 16'h0008; second status read → 16'h0000.
- With UART_RX_PARITY_EN: send 0x03 with parity 1 → status = 16'h0010, FIFO empty. With parity 0 → data read returns 16'h0003.

Source files
------------

// File: rtl/uart_rx_fifo_driver.sv
// UART receiver with a byte FIFO and a 16-bit memory-mapped data/status read port.
// Optional even-parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo_driver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        iFpgaClock,
  input  logic        iCpuReset,
  input  logic        iUartFromPc,
  input  logic        iUartCtrl,
  input  logic        iIoRead,
  input  logic        iAddrSel,
  output logic [15:0] oUartData,
  output logic        oRxNotEmpty
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | half-bit wait, then confirm the start bit is still low
  // S_DATA   | sampling DATA_BITS data bits, LSB first
  // S_PARITY | sampling the even-parity bit (parity build only)
  // S_STOP   | sampling the stop bit, push or flag a framing error
  // S_BREAK  | line held low after a bad stop bit, wait for it to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BPS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  state_t                 r_state, w_state_nxt;
  logic                   r_sync_q1, r_sync_q2, r_rx_prev;
  logic [TW-1:0]          r_timer;
  logic [2:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count, w_count_nxt;
  logic                   r_not_empty, r_rd_prev;
  logic                   r_parity_err, r_framing_err, r_overrun;
  logic [15:0]            r_uart_data;

  logic w_rx, w_fall, w_tick, w_par_bad;
  logic w_push_req, w_push, w_pop, w_full, w_overrun_evt;
  logic w_frame_evt, w_par_evt;
  logic w_rd, w_rd_rise, w_stat_rd;
  logic [7:0]  w_rx_byte, w_count8;
  logic [15:0] w_status;

  assign w_rx      = r_sync_q2;
  assign w_fall    = r_rx_prev & ~w_rx;
  assign w_tick    = (r_timer == '0);
  assign w_rx_byte = 8'(r_shift);

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      r_sync_q1 <= 1'b1;
      r_sync_q2 <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync_q1 <= iUartFromPc;
      r_sync_q2 <= r_sync_q1;
      r_rx_prev <= r_sync_q2;
    end
  end

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_frame_evt = 1'b0;
    w_par_evt   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = w_rx ? S_IDLE : S_DATA;
      S_DATA:
        if (w_tick && r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:
        if (w_tick) begin
          // a parity error is reported whatever the stop bit turns out to be
          w_par_evt = w_par_bad;
          if (w_rx) begin
            w_push_req  = ~w_par_bad;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_evt = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      S_BREAK: if (w_rx) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_fall) begin
            r_timer   <= HALF_RELOAD;
            r_bit_cnt <= '0;
          end
        S_DATA:
          if (w_tick) begin
            r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_timer   <= BIT_RELOAD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        S_START, S_PARITY, S_STOP:
          if (w_tick) r_timer <= BIT_RELOAD;
          else        r_timer <= r_timer - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset)                           r_par_bad <= 1'b0;
    else if (r_state == S_START)             r_par_bad <= 1'b0;
    else if (r_state == S_PARITY && w_tick)  r_par_bad <= w_rx ^ (^r_shift);
  end
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_rd          = iUartCtrl & iIoRead;
  assign w_rd_rise     = w_rd & ~r_rd_prev;
  assign w_stat_rd     = w_rd_rise & iAddrSel;
  assign w_full        = (r_count == FULL_COUNT);
  assign w_pop         = w_rd_rise & ~iAddrSel & (r_count != '0);
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign w_push        = w_push_req & (~w_full | w_pop);
  assign w_overrun_evt = w_push_req & w_full & ~w_pop;
  assign w_count8      = 8'(r_count);
  assign w_status      = {w_count8, 3'b000, r_parity_err, r_framing_err, r_overrun,
                          w_full, r_not_empty};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge iFpgaClock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_byte;
  end

  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_not_empty   <= 1'b0;
      r_rd_prev     <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_uart_data   <= 16'h0000;
    end else begin
      r_rd_prev     <= w_rd;
      r_count       <= w_count_nxt;
      r_not_empty   <= (w_count_nxt != '0);
      r_parity_err  <= (r_parity_err  & ~w_stat_rd) | w_par_evt;
      r_framing_err <= (r_framing_err & ~w_stat_rd) | w_frame_evt;
      r_overrun     <= (r_overrun     & ~w_stat_rd) | w_overrun_evt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_rise) begin
        if (iAddrSel)            r_uart_data <= w_status;
        else if (r_count != '0)  r_uart_data <= {8'h00, r_mem[r_rd_ptr]};
        else                     r_uart_data <= 16'h0000;
      end
    end
  end

  assign oUartData   = r_uart_data;
  assign oRxNotEmpty = r_not_empty;

endmodule

// File: tb/tb_uart_rx_fifo_driver.sv
// Scoreboard bench for uart_rx_fifo_driver: a queue models the FIFO contents and
// sticky flags; reads pop/compute expected words. Parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_fifo_driver;
  localparam int CLK_FREQ = 1_280_000;
  localparam int UART_BPS = 128000;
  localparam int CPB      = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 16;

  logic        clk = 1'b0;
  logic        rst, rx, ctrl, ioread, addr;
  logic [15:0] data;
  logic        ne;

  always #5 clk = ~clk;

  uart_rx_fifo_driver #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iFpgaClock(clk), .iCpuReset(rst), .iUartFromPc(rx), .iUartCtrl(ctrl),
    .iIoRead(ioread), .iAddrSel(addr), .oUartData(data), .oRxNotEmpty(ne)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] q_exp[$];
  logic       m_par, m_fr, m_ovr;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic par_bad;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
    par_bad = par_flip;
`else
    par_bad = 1'b0;
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 2) @(negedge clk);
    if (par_bad) m_par = 1'b1;
    if (!stop_bit) m_fr = 1'b1;
    if (stop_bit && !par_bad) begin
      if (q_exp.size() < DEPTH) q_exp.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic cpu_read(input logic sel, input int hold, output logic [15:0] got);
    @(negedge clk);
    ctrl = 1'b1; ioread = 1'b1; addr = sel;
    @(posedge clk);
    #1 got = data;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    ctrl = 1'b0; ioread = 1'b0; addr = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [15:0] got, exp;
    exp = (q_exp.size() != 0) ? {8'h00, q_exp.pop_front()} : 16'h0000;
    cpu_read(1'b0, 1, got);
    chk(tag, got, exp);
    chk({tag, "_ne"}, {15'b0, ne}, {15'b0, q_exp.size() != 0});
  endtask

  task automatic read_status(input string tag);
    logic [15:0] got, exp;
    exp = {8'(q_exp.size()), 3'b000, m_par, m_fr, m_ovr,
           q_exp.size() == DEPTH, q_exp.size() != 0};
    m_par = 1'b0; m_fr = 1'b0; m_ovr = 1'b0;
    cpu_read(1'b1, 1, got);
    chk(tag, got, exp);
  endtask

  initial begin
    logic [15:0] got;
    rst = 1'b1; rx = 1'b1; ctrl = 1'b0; ioread = 1'b0; addr = 1'b0;
    m_par = 1'b0; m_fr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 16'h0000);
    chk("rst_ne", {15'b0, ne}, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    read_status("rst_status");
    read_data("rst_empty_read");

    send_frame(8'h41, 1'b1, 1'b0);
    read_data("byte_41");
    read_status("status_after_41");

    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    cpu_read(1'b1, 1, got);
    chk("full_status_literal", got, 16'h1003);
    send_frame(8'hAA, 1'b1, 1'b0);
    read_status("overrun_status");
    for (int i = 1; i <= 16; i++) read_data($sformatf("drain_%0d", i));
    read_data("empty_after_drain");
    read_status("status_after_drain");

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    cpu_read(1'b0, 10, got);
    chk("held_read_first", got, {8'h00, q_exp.pop_front()});
    chk("held_read_hold", data, 16'h0011);
    read_status("held_read_count");
    read_data("held_read_second");

    send_frame(8'h55, 1'b0, 1'b0);
    read_status("framing_status");
    read_status("framing_cleared");
    read_data("framing_no_push");

    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    read_status("glitch_status");

    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_rst_data", data, 16'h0000);
    chk("midframe_rst_ne", {15'b0, ne}, 16'h0000);
    rst = 1'b0;
    q_exp.delete();
    m_par = 1'b0; m_fr = 1'b0; m_ovr = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    read_status("midframe_status");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    read_status("parity_bad_status");
    read_data("parity_bad_no_push");
    send_frame(8'h03, 1'b1, 1'b0);
    read_data("parity_good_data");
    send_frame(8'h07, 1'b0, 1'b1);
    read_status("parity_and_framing");
`endif

    send_frame(8'hC3, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_data("recover_c3");
    read_data("recover_3c");
    read_status("final_status");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
